seg7_scan_driver: RTL and testbench

//   Time-multiplexed driver for the 4-digit common-anode seven-segment display on the board.

---
 rtl/seg7_scan_driver.sv | 105 ++++++++++
 tb/tb_seg7_scan_driver.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Inputs are captured once per frame so every displayed frame is coherent.
module seg7_scan_driver #(
    parameter int TICKS_PER_DIGIT = 100_000,
    parameter int BLANK_TICKS     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  digit_en,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame
);

    localparam int CW = $clog2(TICKS_PER_DIGIT);
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_DIGIT - 1);

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_sh_val;
    logic [3:0]    r_sh_en;
    logic [3:0]    r_sh_dp;

    logic          w_last;
    logic          w_bnd;
    logic          w_in_gap;
    logic          w_blank;
    logic [3:0]    w_nib;
    logic [6:0]    w_hex;

    assign w_last = (r_cnt == LAST);
    assign w_bnd  = w_last && (r_idx == 2'd3);

    // A zero-length gap would make the compare constant, so it is elided.
    generate
        if (BLANK_TICKS == 0) begin : g_nogap
            assign w_in_gap = 1'b0;
        end else begin : g_gap
            assign w_in_gap = (r_cnt < CW'(BLANK_TICKS));
        end
    endgenerate

    assign w_blank = w_in_gap || !r_sh_en[r_idx];
    assign w_nib   = r_sh_val[4*r_idx +: 4];

    always_comb begin
        w_hex = 7'h7F;
        case (w_nib)
            4'h0: w_hex = 7'h40;
            4'h1: w_hex = 7'h79;
            4'h2: w_hex = 7'h24;
            4'h3: w_hex = 7'h30;
            4'h4: w_hex = 7'h19;
            4'h5: w_hex = 7'h12;
            4'h6: w_hex = 7'h02;
            4'h7: w_hex = 7'h78;
            4'h8: w_hex = 7'h00;
            4'h9: w_hex = 7'h10;
            4'hA: w_hex = 7'h08;
            4'hB: w_hex = 7'h03;
            4'hC: w_hex = 7'h46;
            4'hD: w_hex = 7'h21;
            4'hE: w_hex = 7'h06;
            4'hF: w_hex = 7'h0E;
            default: w_hex = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_idx    <= 2'd0;
            r_sh_val <= 16'h0;
            r_sh_en  <= 4'h0;
            r_sh_dp  <= 4'h0;
        end else begin
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            if (w_last) r_idx <= r_idx + 2'd1;
            if (w_bnd) begin
                r_sh_val <= value;
                r_sh_en  <= digit_en;
                r_sh_dp  <= dp_in;
            end
        end
    end

    // Pins are registered from the current state: one cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an    <= 4'b1111;
            seg   <= 7'h7F;
            dp    <= 1'b1;
            frame <= 1'b0;
        end else begin
            an    <= w_blank ? 4'b1111 : ~(4'b0001 << r_idx);
            seg   <= w_blank ? 7'h7F : w_hex;
            dp    <= w_blank ? 1'b1 : ~r_sh_dp[r_idx];
            frame <= w_bnd;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with TICKS_PER_DIGIT=8, BLANK_TICKS=2.
// Edge e after release shows the state held after edge e-1; frames are 32 cycles.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  digit_en = 4'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame;

    int total = 0;
    int bad = 0;
    int ecount = 0;

    logic [6:0] hex_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] seg1234 [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [3:0] one = 4'b0001;

    seg7_scan_driver #(.TICKS_PER_DIGIT(8), .BLANK_TICKS(2)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .digit_en(digit_en), .dp_in(dp_in),
        .an(an), .seg(seg), .dp(dp), .frame(frame)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if ($countones(~an) > 1) begin
                bad++;
                $display("FAIL onehot_an t=%0t an=%b (more than one anode low)", $time, an);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk); #1; ecount++;
    endtask

    task automatic run_to(input int e);
        while (ecount < e) step();
    endtask

    task automatic apply_reset(input logic [15:0] v, input logic [3:0] en, input logic [3:0] d);
        rst_n = 1'b0; value = v; digit_en = en; dp_in = d;
        repeat (2) @(posedge clk);
        #3; rst_n = 1'b1; ecount = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total += 4;
        if (an !== 4'b1111) begin bad++; $display("FAIL reset_an got=%b exp=1111", an); end
        if (seg !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        if (dp !== 1'b1) begin bad++; $display("FAIL reset_dp got=%b exp=1", dp); end
        if (frame !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b exp=0", frame); end
        apply_reset(16'h1234, 4'hF, 4'h0);
        for (int e = 1; e <= 34; e++) begin
            step();
            total += 2;
            if (an !== 4'b1111) begin bad++; $display("FAIL first_frame_blank e=%0d an=%b exp=1111", e, an); end
            if (frame !== (e == 32)) begin bad++; $display("FAIL first_frame_pulse e=%0d frame=%b exp=%b", e, frame, e == 32); end
        end
    endtask

    task automatic test_scan();
        int s, cnt, idx;
        logic [3:0] ea;
        logic [6:0] es;
        for (int e = 35; e <= 96; e++) begin
            step();
            s = ecount - 1; cnt = s % 8; idx = (s / 8) % 4;
            ea = (cnt >= 2) ? ~(one << idx) : 4'b1111;
            es = (cnt >= 2) ? seg1234[idx] : 7'h7F;
            total += 4;
            if (an !== ea) begin bad++; $display("FAIL scan_an e=%0d got=%b exp=%b", ecount, an, ea); end
            if (seg !== es) begin bad++; $display("FAIL scan_seg e=%0d got=%h exp=%h", ecount, seg, es); end
            if (dp !== 1'b1) begin bad++; $display("FAIL scan_dp e=%0d got=%b exp=1", ecount, dp); end
            if (frame !== (ecount % 32 == 0)) begin bad++; $display("FAIL scan_frame e=%0d got=%b", ecount, frame); end
        end
    endtask

    task automatic test_mask_dp();
        int s, cnt, idx;
        logic lit;
        logic [3:0] ea;
        logic [6:0] es;
        logic ed;
        apply_reset(16'hABCD, 4'b0101, 4'b0100);
        run_to(32);
        for (int e = 33; e <= 64; e++) begin
            step();
            s = ecount - 1; cnt = s % 8; idx = (s / 8) % 4;
            lit = (cnt >= 2) && (idx == 0 || idx == 2);
            ea = lit ? ~(one << idx) : 4'b1111;
            es = !lit ? 7'h7F : (idx == 0 ? 7'h21 : 7'h03);
            ed = !(lit && idx == 2);
            total += 3;
            if (an !== ea) begin bad++; $display("FAIL mask_an e=%0d got=%b exp=%b", ecount, an, ea); end
            if (seg !== es) begin bad++; $display("FAIL mask_seg e=%0d got=%h exp=%h", ecount, seg, es); end
            if (dp !== ed) begin bad++; $display("FAIL mask_dp e=%0d got=%b exp=%b", ecount, dp, ed); end
        end
    endtask

    task automatic test_back_to_back();
        int s, cnt;
        logic [6:0] es;
        apply_reset(16'h1111, 4'hF, 4'h0);
        run_to(32);
        for (int e = 33; e <= 96; e++) begin
            if (ecount == 48) value = 16'h2222;
            step();
            s = ecount - 1; cnt = s % 8;
            es = (cnt < 2) ? 7'h7F : (ecount <= 64 ? 7'h79 : 7'h24);
            total++;
            if (seg !== es) begin bad++; $display("FAIL coherent_seg e=%0d got=%h exp=%h", ecount, seg, es); end
        end
    endtask

    task automatic test_async_reset();
        apply_reset(16'h1234, 4'hF, 4'h0);
        run_to(52);
        total++;
        if (an !== 4'b1011) begin bad++; $display("FAIL d2_lit got=%b exp=1011", an); end
        #2 rst_n = 1'b0;
        #1;
        total += 3;
        if (an !== 4'b1111) begin bad++; $display("FAIL async_an got=%b exp=1111", an); end
        if (seg !== 7'h7F) begin bad++; $display("FAIL async_seg got=%h exp=7f", seg); end
        if (dp !== 1'b1) begin bad++; $display("FAIL async_dp got=%b exp=1", dp); end
        repeat (2) @(posedge clk);
        #3; rst_n = 1'b1; ecount = 0;
        for (int e = 1; e <= 34; e++) begin
            step();
            total++;
            if (an !== 4'b1111) begin bad++; $display("FAIL restart_blank e=%0d an=%b exp=1111", e, an); end
        end
        step();
        total += 2;
        if (an !== 4'b1110) begin bad++; $display("FAIL restart_d0_an got=%b exp=1110", an); end
        if (seg !== 7'h19) begin bad++; $display("FAIL restart_d0_seg got=%h exp=19", seg); end
    endtask

    task automatic test_hex_sweep();
        apply_reset(16'h0000, 4'b0001, 4'h0);
        for (int k = 0; k < 16; k++) begin
            run_to(32 * (k + 1) + 3);
            total += 2;
            if (an !== 4'b1110) begin bad++; $display("FAIL sweep_an k=%0d got=%b exp=1110", k, an); end
            if (seg !== hex_tbl[k]) begin bad++; $display("FAIL sweep_seg k=%0d got=%h exp=%h", k, seg, hex_tbl[k]); end
            value = 16'(k + 1);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_mask_dp();
        test_back_to_back();
        test_async_reset();
        test_hex_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
